sha_round_scheduler: RTL and testbench

Sequencer for the shared `sha_unit` compression datapath. On a `start` pulse it drives `round` and `Kt` through one or more 64-round passes (double SHA-256 by default), and flags exactly when `H1` is valid for each pass. It can be aborted at any time. It sits between the job/nonce logic and one or more `sha_unit` instances that share a single round/Kt broadcast.

---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sha_round_scheduler_if.sv | 22 ++
 rtl/sha256_k_rom.sv | 9 +
 rtl/sha_round_scheduler.sv | 103 ++++++++++
 tb/tb_sha_round_scheduler.sv | 136 +++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants and scheduler state encoding
package sha256_pkg;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'd63;

endpackage

// File: rtl/sha_round_scheduler_if.sv
// rtl/sha_round_scheduler_if.sv - job control and round/Kt broadcast bundle
interface sha_round_scheduler_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        run;
    logic [5:0]  round;
    logic [31:0] Kt;
    logic [1:0]  pass;
    logic        capture;
    logic        done;

    modport master (
        input  start, abort,
        output busy, run, round, Kt, pass, capture, done
    );

    modport slave (
        output start, abort,
        input  busy, run, round, Kt, pass, capture, done
    );
endinterface

// File: rtl/sha256_k_rom.sv
// rtl/sha256_k_rom.sv - combinational round index to SHA-256 K lookup
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [31:0] k
);
    assign k = K_TABLE[idx];
endmodule

// File: rtl/sha_round_scheduler.sv
// rtl/sha_round_scheduler.sv - sequences round/Kt through PASSES compression passes
module sha_round_scheduler
    import sha256_pkg::*;
#(
    parameter int PASSES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sha_round_scheduler_if.master  bus
);
    localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

    state_t      state;
    logic [5:0]  round_q;
    logic [31:0] kt_q;
    logic [1:0]  pass_q;
    logic        busy_q;
    logic        run_q;
    logic        capture_q;
    logic        done_q;
    logic [5:0]  rom_idx;
    logic [31:0] rom_k;

    // The ROM looks up the round that will be live next cycle, so Kt lands
    // in the same cycle as its round; every non-advancing path returns to K[0].
    always_comb begin
        rom_idx = 6'd0;
        if (state == ST_RUN && !bus.abort && round_q != LAST_ROUND)
            rom_idx = round_q + 6'd1;
    end

    sha256_k_rom u_k_rom (
        .idx (rom_idx),
        .k   (rom_k)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            round_q   <= 6'd0;
            kt_q      <= K_TABLE[0];
            pass_q    <= 2'd0;
            busy_q    <= 1'b0;
            run_q     <= 1'b0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            kt_q      <= rom_k;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            if (bus.abort) begin
                state   <= ST_IDLE;
                round_q <= 6'd0;
                pass_q  <= 2'd0;
                busy_q  <= 1'b0;
                run_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state   <= ST_RUN;
                            round_q <= 6'd0;
                            pass_q  <= 2'd0;
                            busy_q  <= 1'b1;
                            run_q   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (round_q == LAST_ROUND) begin
                            state     <= ST_CAPTURE;
                            round_q   <= 6'd0;
                            run_q     <= 1'b0;
                            capture_q <= 1'b1;
                            done_q    <= (pass_q == LAST_PASS);
                        end else begin
                            round_q <= round_q + 6'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pass_q != LAST_PASS) begin
                            state  <= ST_RUN;
                            pass_q <= pass_q + 2'd1;
                            run_q  <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            pass_q <= 2'd0;
                            busy_q <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.run     = run_q;
    assign bus.round   = round_q;
    assign bus.Kt      = kt_q;
    assign bus.pass    = pass_q;
    assign bus.capture = capture_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_sha_round_scheduler.sv
// tb/tb_sha_round_scheduler.sv - directed self-checking bench for sha_round_scheduler
module tb_sha_round_scheduler;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    sha_round_scheduler_if bus_if ();

    sha_round_scheduler #(.PASSES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    localparam logic [43:0] IDLE_VEC = {1'b0, 1'b0, 6'd0, 32'h428a2f98, 2'd0, 1'b0, 1'b0};

    function automatic logic [43:0] obs_vec();
        return {bus_if.busy, bus_if.run, bus_if.round, bus_if.Kt,
                bus_if.pass, bus_if.capture, bus_if.done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for job cycle c (1..130) with two passes of 65 cycles.
    function automatic logic [43:0] job_vec(input int c);
        int p, r;
        p = (c - 1) / 65;
        r = (c - 1) % 65;
        if (r == 64)
            return {1'b1, 1'b0, 6'd0, 32'h428a2f98, 2'(p), 1'b1, (p == 1)};
        return {1'b1, 1'b1, 6'(r), K_TABLE[r], 2'(p), 1'b0, 1'b0};
    endfunction

    // Caller sets start=1 before calling; first step is the edge that samples it.
    task automatic run_job(input bit hold);
        for (int c = 1; c <= 130; c++) begin
            step();
            if (!hold && c == 1) bus_if.start = 1'b0;
            chk($sformatf("job_c%0d", c), 64'(obs_vec()), 64'(job_vec(c)));
            if (c == 2)  chk("k_round1",  64'(bus_if.Kt), 64'h71374491);
            if (c == 64) chk("k_round63", 64'(bus_if.Kt), 64'hc67178f2);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", 64'(obs_vec()), 64'(IDLE_VEC));
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", 64'(obs_vec()), 64'(IDLE_VEC));

        // single two-pass job
        bus_if.start = 1'b1;
        run_job(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("idle_post_job%0d", i), 64'(obs_vec()), 64'(IDLE_VEC));
        end

        // abort at round 40 of pass 1 (job cycle 106)
        bus_if.start = 1'b1;
        for (int c = 1; c <= 106; c++) begin
            step();
            if (c == 1) bus_if.start = 1'b0;
        end
        chk("abort_pre_round", 64'(bus_if.round), 64'd40);
        chk("abort_pre_pass",  64'(bus_if.pass),  64'd1);
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        chk("abort_idle", 64'(obs_vec()), 64'(IDLE_VEC));
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("abort_quiet%0d", i), 64'({bus_if.busy, bus_if.capture, bus_if.done}), 64'd0);
        end
        bus_if.start = 1'b1;
        run_job(1'b0);
        step();

        // start and abort together in IDLE
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        step();
        chk("collide_idle0", 64'(obs_vec()), 64'(IDLE_VEC));
        step();
        chk("collide_idle1", 64'(obs_vec()), 64'(IDLE_VEC));
        bus_if.abort = 1'b0;

        // start held high: jobs begin at cycles 0, 131, 262
        run_job(1'b1);
        step();
        chk("restart_gap1", 64'(obs_vec()), 64'(IDLE_VEC));
        run_job(1'b1);
        step();
        chk("restart_gap2", 64'(obs_vec()), 64'(IDLE_VEC));
        step();
        bus_if.start = 1'b0;
        chk("restart_third", 64'(obs_vec()), 64'(job_vec(1)));

        // asynchronous reset mid-run at round 30
        for (int i = 0; i < 30; i++) step();
        chk("pre_reset_round", 64'(bus_if.round), 64'd30);
        reset_n = 1'b0;
        #1;
        chk("async_reset_vals", 64'(obs_vec()), 64'(IDLE_VEC));
        #3;
        reset_n = 1'b1;
        step();
        chk("idle_after_rerun_reset", 64'(obs_vec()), 64'(IDLE_VEC));
        step();
        chk("kt_after_reset", 64'(bus_if.Kt), 64'h428a2f98);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
